// File: rtl/msx_slot_io_if.sv
// msx_slot_io_if: MSX slot I/O front-end for the VDP port window; SLOT_IO_WAIT_EN enables Z80 wait, otherwise overflow_err is reported
module msx_slot_io_if #(
  parameter logic [7:0] IO_BASE = 8'h88,
  parameter int FILTER_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slot_iorq_n,
  input  logic       slot_rd_n,
  input  logic       slot_wr_n,
  input  logic [7:0] slot_a,
  input  logic [7:0] slot_d_in,
  output logic [7:0] slot_d_out,
  output logic       slot_data_dir,
  output logic       slot_wait,
  output logic       bus_valid,
  input  logic       bus_ready,
  output logic       bus_write,
  output logic [1:0] bus_address,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rdata_en,
  output logic       overflow_err
);
  typedef enum logic [2:0] {IDLE, FILTER, REQ, RDATA, RELEASE} state_t;
  state_t state, nxt;
  logic [18:0] s1, s2;
  logic iorq_s, rd_s, wr_s, dec, wr_hit, rd_hit, hit, hit_q, last_w;
  logic [7:0] a_s, d_s;
  logic [3:0] cnt;
  assign {iorq_s, rd_s, wr_s, a_s, d_s} = s2;
  assign dec = a_s[7:2] == IO_BASE[7:2];
  assign wr_hit = !iorq_s && !wr_s && rd_s && dec;
  assign rd_hit = !iorq_s && !rd_s && wr_s && dec;
  assign hit = wr_hit || rd_hit;
  // two-stage synchronizer; strobes idle high
  always_ff @(posedge clk)
    if (reset) begin
      s1 <= 19'h70000;
      s2 <= 19'h70000;
    end else begin
      s1 <= {slot_iorq_n, slot_rd_n, slot_wr_n, slot_a, slot_d_in};
      s2 <= s1;
    end
  // counts consecutive samples of the same hit type, saturating at 15
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= 4'd0;
      hit_q <= 1'b0;
      last_w <= 1'b0;
    end else begin
      cnt <= !hit ? 4'd0 : (!hit_q || last_w != wr_hit) ? 4'd1 : (cnt == 4'd15) ? cnt : cnt + 4'd1;
      hit_q <= hit;
      last_w <= wr_hit;
    end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  // next-state logic; RELEASE waits for /IORQ to end so each Z80 cycle yields one request
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = hit ? FILTER : IDLE;
      FILTER:  nxt = !hit ? IDLE : (cnt == 4'(FILTER_CYCLES) && last_w == wr_hit) ? REQ : FILTER;
      REQ:     nxt = !bus_ready ? REQ : bus_write ? RELEASE : RDATA;
      RDATA:   nxt = bus_rdata_en ? RELEASE : RDATA;
      RELEASE: nxt = iorq_s ? IDLE : RELEASE;
      default: nxt = IDLE;
    endcase
  end
  // outputs decoded from state
  always_comb begin
    bus_valid = state == REQ;
    slot_data_dir = !bus_write && (state == RDATA || state == RELEASE) && !rd_s;
`ifdef SLOT_IO_WAIT_EN
    slot_wait = state == FILTER || state == REQ || state == RDATA;
`else
    slot_wait = 1'b0;
`endif
  end
  // request fields captured once on acceptance, read data on the VDP pulse
  always_ff @(posedge clk)
    if (reset) begin
      bus_address <= 2'd0;
      bus_write <= 1'b0;
      bus_wdata <= 8'd0;
      slot_d_out <= 8'd0;
      overflow_err <= 1'b0;
    end else begin
      if (state == FILTER && nxt == REQ) begin
        bus_address <= a_s[1:0];
        bus_write <= wr_hit;
        bus_wdata <= d_s;
      end
      if (state == RDATA && bus_rdata_en) slot_d_out <= bus_rdata;
`ifdef SLOT_IO_WAIT_EN
      overflow_err <= 1'b0;
`else
      overflow_err <= (state == REQ || state == RDATA) && hit && !hit_q;
`endif
    end
endmodule

// File: tb/tb_msx_slot_io_if.sv
// tb_msx_slot_io_if: directed self-checking bench for msx_slot_io_if
`timescale 1ns/1ps
module tb_msx_slot_io_if;
`ifdef SLOT_IO_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic slot_iorq_n = 1'b1, slot_rd_n = 1'b1, slot_wr_n = 1'b1;
  logic [7:0] slot_a = 8'd0, slot_d_in = 8'd0, slot_d_out, bus_wdata, bus_rdata = 8'd0;
  logic slot_data_dir, slot_wait, bus_valid, bus_ready = 1'b0, bus_write, bus_rdata_en = 1'b0, overflow_err;
  logic [1:0] bus_address;
  logic [10:0] q[$];
  int passed = 0, total = 0, valid_cnt = 0, wait_cnt = 0, ovf_cnt = 0, v0, w0, h0;
  msx_slot_io_if dut (
    .clk(clk), .reset(reset), .slot_iorq_n(slot_iorq_n), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
    .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out), .slot_data_dir(slot_data_dir),
    .slot_wait(slot_wait), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
    .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en),
    .overflow_err(overflow_err)
  );
  always #6 clk = ~clk;
  // bus_ready only changes just after posedge, so negedge values equal the next edge's
  always @(negedge clk) begin
    if (bus_valid && bus_ready) q.push_back({bus_write, bus_address, bus_wdata});
    if (bus_valid) valid_cnt++;
    if (slot_wait) wait_cnt++;
    if (overflow_err) ovf_cnt++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    tick(3);
    check("rst_valid", bus_valid, 0);
    check("rst_wait", slot_wait, 0);
    check("rst_dir", slot_data_dir, 0);
    check("rst_dout", slot_d_out, 0);
    check("rst_write", bus_write, 0);
    check("rst_addr", bus_address, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_ovf", overflow_err, 0);
    reset = 1'b0;
    tick(2);
    // write 0x89 <- 0x0E, latency 7 clk
    bus_ready = 1'b1;
    slot_a = 8'h89; slot_d_in = 8'h0E; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    tick(6);
    check("w1_valid_early", bus_valid, 0);
    tick(1);
    check("w1_valid", bus_valid, 1);
    check("w1_fields", {bus_write, bus_address, bus_wdata}, {1'b1, 2'd1, 8'h0E});
    tick(1);
    check("w1_valid_drop", bus_valid, 0);
    check("w1_wait", slot_wait, 0);
    tick(3);
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    tick(10);
    check("w1_count", q.size(), 1);
    check("w1_entry", q[0], {1'b1, 2'd1, 8'h0E});
    // write 0x8B <- 0xC3 with bus_ready held low 200 clk
    bus_ready = 1'b0;
    slot_a = 8'h8B; slot_d_in = 8'hC3; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    tick(12);
    check("w2_wait", slot_wait, WAIT_EN);
    tick(200);
    check("w2_valid_held", bus_valid, 1);
    check("w2_fields", {bus_write, bus_address, bus_wdata}, {1'b1, 2'd3, 8'hC3});
    check("w2_no_hs", q.size(), 1);
    bus_ready = 1'b1;
    tick(1);
    check("w2_valid_done", bus_valid, 0);
    check("w2_wait_done", slot_wait, 0);
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    tick(6);
    check("w2_count", q.size(), 2);
    // read 0x88 returning 0x5A 30 clk after accept
    slot_a = 8'h88; slot_d_in = 8'h00; slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
    tick(7);
    check("r_valid", bus_valid, 1);
    check("r_fields", {bus_write, bus_address}, 3'b000);
    tick(1);
    check("r_dir_early", slot_data_dir, 1);
    check("r_dout_stale", slot_d_out, 0);
    tick(29);
    bus_rdata = 8'h5A; bus_rdata_en = 1'b1;
    tick(1);
    bus_rdata_en = 1'b0;
    check("r_dout", slot_d_out, 8'h5A);
    check("r_dir", slot_data_dir, 1);
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1;
    tick(1);
    check("r_dir_sync", slot_data_dir, 1);
    tick(1);
    check("r_dir_off", slot_data_dir, 0);
    check("r_dout_hold", slot_d_out, 8'h5A);
    tick(4);
    check("r_count", q.size(), 3);
    check("r_entry", q[2][10:8], 3'b000);
    // non-decoded port and a 2-clk glitch
    v0 = valid_cnt; w0 = wait_cnt;
    slot_a = 8'h98; slot_d_in = 8'h77; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    tick(12);
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    tick(4);
    slot_a = 8'h89; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    tick(2);
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    tick(10);
    check("ign_valid", valid_cnt - v0, 0);
    check("ign_wait", wait_cnt - w0, WAIT_EN ? 2 : 0);
    check("ign_count", q.size(), 3);
    // 16 jittered back-to-back writes to 0x88
    for (int i = 0; i < 16; i++) begin
      slot_a = 8'h88; slot_d_in = 8'(i * 13 + 5);
      #10;
      slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
      #(120 + int'($urandom_range(80)));
      slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
      #(40 + int'($urandom_range(80)));
    end
    tick(10);
    check("burst_count", q.size(), 19);
    for (int i = 0; i < 16; i++) check($sformatf("burst_%0d", i), q[3 + i], {1'b1, 2'd0, 8'(i * 13 + 5)});
    // second write while the first request is stalled
    h0 = ovf_cnt;
    bus_ready = 1'b0;
    slot_a = 8'h89; slot_d_in = 8'h11; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    tick(15);
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    tick(5);
    slot_d_in = 8'h22; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    tick(15);
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    tick(5);
    check("ovf_fields", {bus_write, bus_address, bus_wdata}, {1'b1, 2'd1, 8'h11});
    bus_ready = 1'b1;
    tick(3);
    check("ovf_pulses", ovf_cnt - h0, WAIT_EN ? 0 : 1);
    check("ovf_count", q.size(), 20);
    check("ovf_entry", q[19], {1'b1, 2'd1, 8'h11});
    tick(5);
    check("ovf_single", q.size(), 20);
    // reset while in REQ
    bus_ready = 1'b0;
    slot_a = 8'h8A; slot_d_in = 8'h33; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    tick(10);
    check("mid_valid", bus_valid, 1);
    reset = 1'b1;
    tick(1);
    check("mid_valid_rst", bus_valid, 0);
    check("mid_fields_rst", {bus_write, bus_address, bus_wdata}, 11'd0);
    check("mid_dout_rst", slot_d_out, 0);
    check("mid_misc_rst", {slot_data_dir, slot_wait, overflow_err}, 3'b000);
    reset = 1'b0; slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    tick(8);
    check("mid_after", bus_valid, 0);
    check("mid_count", q.size(), 20);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
